// File: rtl/led_mode_pkg.sv
// Shared definitions for the LED mode processors: FSM state encoding and
// default LED count.
package led_mode_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } led_state_t;

  localparam int LED_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/led_fill_reverse_if.sv
// Control and pattern bundle between the top-level mode selector (master)
// and the fill-reverse LED mode processor (slave).
interface led_fill_reverse_if
  import led_mode_pkg::*;
#(
  parameter int WIDTH = LED_WIDTH_DEFAULT
);

  // There is no valid/ready pair. tick is a one-clk strobe that is consumed on
  // the edge where it is seen (pause=0, enable=1) and never queued. pause and
  // enable are levels. All outputs are registered and valid on every clk.
  logic             tick;
  logic             pause;
  logic             enable;
  logic [WIDTH-1:0] leds;
  logic [3:0]       fill_count;
  logic             cycle_done;
  logic             busy;
  led_state_t       state_dbg;

  modport master (
    output tick, pause, enable,
    input  leds, fill_count, cycle_done, busy, state_dbg
  );

  modport slave (
    input  tick, pause, enable,
    output leds, fill_count, cycle_done, busy, state_dbg
  );

endinterface

// File: rtl/led_fill_reverse.sv
// Fill-reverse LED mode: lights LEDs from the top bit down to bit 0, holds the
// all-on pattern for HOLD_TICKS steps, then blanks and starts over.
module led_fill_reverse
  import led_mode_pkg::*;
#(
  parameter int WIDTH      = LED_WIDTH_DEFAULT,
  parameter int HOLD_TICKS = 2
) (
  input  logic              clk,
  input  logic              reset,
  led_fill_reverse_if.slave bus
);

  localparam int         HCW       = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [3:0] LAST_FILL = 4'(WIDTH - 1);
  localparam logic [HCW-1:0] LAST_HOLD = HCW'(HOLD_TICKS - 1);

  led_state_t       state;
  logic [HCW-1:0]   hold_cnt;
  logic             step;
  logic [WIDTH-1:0] fill_bit;

  assign step          = bus.tick & ~bus.pause & bus.enable;
  assign bus.state_dbg = state;

  // Next LED to light; only used in FILL, where fill_count < WIDTH.
  always_comb begin
    fill_bit = WIDTH'(1) << (WIDTH - 1 - int'(bus.fill_count));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_FILL;
      hold_cnt       <= '0;
      bus.leds       <= '0;
      bus.fill_count <= '0;
      bus.cycle_done <= 1'b0;
      bus.busy       <= 1'b0;
    end else if (!bus.enable) begin
      state          <= ST_FILL;
      hold_cnt       <= '0;
      bus.leds       <= '0;
      bus.fill_count <= '0;
      bus.cycle_done <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.cycle_done <= 1'b0;
      if (step) begin
        case (state)
          ST_FILL: begin
            bus.leds       <= bus.leds | fill_bit;
            bus.fill_count <= bus.fill_count + 4'd1;
            bus.busy       <= 1'b1;
            if (bus.fill_count == LAST_FILL) begin
              state    <= ST_HOLD;
              hold_cnt <= '0;
            end
          end
          ST_HOLD: begin
            // The last hold step blanks and flags the cycle end for one clk.
            if (hold_cnt == LAST_HOLD) begin
              state          <= ST_FILL;
              hold_cnt       <= '0;
              bus.leds       <= '0;
              bus.fill_count <= '0;
              bus.cycle_done <= 1'b1;
              bus.busy       <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + HCW'(1);
            end
          end
          default: state <= ST_FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_fill_reverse.sv
// Bench for led_fill_reverse: directed sequences plus random tick/pause/enable
// traffic, scored against a step-position model of the pattern.
module tb_led_fill_reverse;

  localparam int W  = 8;
  localparam int H  = 2;
  localparam int EW = W + 6;

  logic clk = 1'b0;
  logic reset;

  led_fill_reverse_if #(.WIDTH(W)) bus ();

  led_fill_reverse #(.WIDTH(W), .HOLD_TICKS(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock/reset
  always #5 clk = ~clk;

  // scoreboard: {leds, fill_count, cycle_done, busy}
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: position within the W+H step cycle (0 = blank).
  int   m_pos  = 0;
  logic m_done = 1'b0;

  function automatic logic [EW-1:0] expect_vec(input int pos, input logic done);
    logic [W-1:0] l;
    int           f;
    if (pos == 0) begin
      l = '0;
      f = 0;
    end else if (pos >= W) begin
      l = '1;
      f = W;
    end else begin
      l = '0;
      for (int i = 0; i < pos; i++) l[W-1-i] = 1'b1;
      f = pos;
    end
    return {l, 4'(f), done, (l != '0)};
  endfunction

  // driver tasks
  task automatic cyc(input logic t, input logic p, input logic e);
    bus.tick   = t;
    bus.pause  = p;
    bus.enable = e;
    @(posedge clk);
    m_done = 1'b0;
    if (reset || !e) begin
      m_pos = 0;
    end else if (t && !p) begin
      if (m_pos == W + H - 1) begin
        m_pos  = 0;
        m_done = 1'b1;
      end else begin
        m_pos++;
      end
    end
    exp_q.push_back(expect_vec(m_pos, m_done));
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b1);
  endtask

  // Pulse reset between edges; the result must be visible before any clk edge.
  task automatic mid_reset();
    #1;
    reset  = 1'b1;
    m_pos  = 0;
    m_done = 1'b0;
    void'(exp_q.pop_back());
    exp_q.push_back(expect_vec(0, 1'b0));
    #5;
    reset = 1'b0;
  endtask

  // monitor
  initial begin : monitor
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.leds, bus.fill_count, bus.cycle_done, bus.busy};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL out_check t=%0t got leds=%b fill=%0d done=%b busy=%b required leds=%b fill=%0d done=%b busy=%b",
                   $time, a[EW-1:6], a[5:2], a[1], a[0], e[EW-1:6], e[5:2], e[1], e[0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    reset      = 1'b1;
    bus.tick   = 1'b0;
    bus.pause  = 1'b0;
    bus.enable = 1'b0;
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    reset = 1'b0;

    steps(3);

    mid_reset();
    steps(10);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);

    mid_reset();
    steps(4);
    repeat (5) cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    steps(1);

    mid_reset();
    steps(5);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    steps(1);

    mid_reset();
    steps(9);
    mid_reset();
    steps(1);

    mid_reset();
    steps(30);

    repeat (400) begin
      cyc(($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 15) != 0));
      if ($urandom_range(0, 49) == 0) mid_reset();
    end

    // drain
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
